fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing one fifo write port (wr_en/wr_data/wr_full) among NUM_REQ write-side requesters.
- Sits between several write stimulus or producer blocks and a single fifo instance, in the fifo write clock domain.
- Grants whole bursts of up to BURST_LEN beats so that each requester's data stays contiguous in the fifo.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..16.
- BYTE_WIDTH, 8, data bytes per beat; data width is BYTE_WIDTH*8 bits.
- BURST_LEN, 16, maximum beats per grant; 0 means unlimited (grant held until the requester idles).
- CNT_WIDTH, 8, beat counter width; must satisfy BURST_LEN < 2^CNT_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-high.
- s_wr_en  in  NUM_REQ  per-requester write request/valid; bit i belongs to requester i.
- s_wr_data  in  NUM_REQ*BYTE_WIDTH*8  concatenated data; requester i occupies slice i.
- s_wr_full  out  NUM_REQ  per-requester backpressure; 1 = beat not accepted.
- m_wr_en  out  1  to fifo wr_en.
- m_wr_data  out  BYTE_WIDTH*8  to fifo wr_data.
- m_wr_full  in  1  from fifo wr_full.
- grant_valid  out  1  high while a burst grant is active.
- grant_idx  out  clog2(NUM_REQ)  index of the granted requester; valid when grant_valid=1.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset (rst=1 at a clk edge):
  - State = IDLE, grant_idx=0, grant_valid=0, beat count=0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
  - All s_wr_full=1, m_wr_en=0.
  - m_wr_data is 0 whenever no grant is active.
- State IDLE:
  - If any s_wr_en bit is high, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register that index as grant_idx, clear the beat count, go to BURST.
  - No beat transfers in an IDLE cycle, so arbitration costs 1 cycle per burst.
  - If no s_wr_en bit is high, stay in IDLE.
- State BURST (grant g):
  - Combinational: m_wr_data = slice g of s_wr_data.
  - Combinational: m_wr_en = s_wr_en[g] & ~m_wr_full.
  - Combinational: s_wr_full[g] = m_wr_full; all other s_wr_full bits = 1.
  - A beat is transferred when m_wr_en=1. Beat count increments per beat (CNT_WIDTH bits).
- Burst termination (return to IDLE next cycle, last_grant <= g):
  - BURST_LEN != 0 and a beat transfers while count == BURST_LEN-1; that beat is still written.
  - Or s_wr_en[g]=0 in any BURST cycle; the requester is treated as idle and the grant is released.
- Backpressure:
  - m_wr_full=1 with s_wr_en[g]=1 holds the grant. There are no beats and no timeout; the count is frozen.
- Requesters must hold data stable while their s_wr_en=1 and s_wr_full=1.
- Simultaneous requests: strict rotation. After g completes, priority starts at g+1, so a sole continuous requester is re-granted after one IDLE cycle.
- Request drop after grant: no beat transfers and the grant is released. This is legal and costs no data.
- rst asserted mid-burst: the grant aborts immediately and priority returns to requester 0. A beat presented in the reset cycle is not written (m_wr_en=0 during reset).
- grant_valid = (state==BURST).

Optional Feature:
- Macro: FIFO_WR_ARB_ID_TAG_EN.
- When defined:
  - m_wr_data widens to BYTE_WIDTH*8+clog2(NUM_REQ) bits.
  - The upper bits carry grant_idx, the lower bits carry data, so readers can demultiplex the source.
  - The downstream fifo BYTE_WIDTH must be sized to match by the instantiating level.
- When undefined: m_wr_data is exactly BYTE_WIDTH*8 bits and no tag is present.

Test Plan:
- Reset check: rst=1 for 3 cycles with all s_wr_en=1.
  -> m_wr_en=0, s_wr_full=4'b1111, grant_valid=0.
  -> First grant after release is requester 0.
- Single requester, BURST_LEN=16: requester 2 streams 40 beats (values 0..39), m_wr_full=0.
  -> Bursts of 16, 16, 8 beats, each separated by 1 IDLE cycle.
  -> fifo receives 0..39 in order; grant_idx=2 throughout.
- Round-robin fairness: all 4 requesters stream continuously, BURST_LEN=4.
  -> Grant order 0,1,2,3,0,1…; each burst is exactly 4 beats.
  -> Each requester's s_wr_full=1 outside its burst.
- Backpressure: m_wr_full=1 for 10 cycles mid-burst at beat 5.
  -> m_wr_en=0 and count frozen at 5 during the stall.
  -> Burst resumes and completes 16 beats with no loss or duplication.
- Early release: requester 1 drops s_wr_en after 3 beats while requester 3 is waiting.
  -> Grant returns to IDLE, then grants 3; exactly 3 beats from requester 1 are written.
- Mid-burst reset plus tag: with FIFO_WR_ARB_ID_TAG_EN defined, rst pulses at beat 7 of requester 3's burst.
  -> Beat 7 is not written; the next grant goes to requester 0.
  -> Written words carry tag bits equal to the source index (e.g. 2'b11 for requester 3).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one fifo write port among
// NUM_REQ producers. Grants whole bursts of up to BURST_LEN beats (0 = until
// the requester idles) so each producer's data stays contiguous in the fifo.
// One IDLE cycle of arbitration precedes every burst.
// Optional build macro: FIFO_WR_ARB_ID_TAG_EN prepends grant_idx above the
// data on m_wr_data so a reader can demultiplex the source.
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int BYTE_WIDTH = 8,
    parameter  int BURST_LEN  = 16,
    parameter  int CNT_WIDTH  = 8,
    localparam int IDX_W      = $clog2(NUM_REQ),
    localparam int DATA_W     = BYTE_WIDTH * 8,
`ifdef FIFO_WR_ARB_ID_TAG_EN
    localparam int OUT_W      = DATA_W + IDX_W
`else
    localparam int OUT_W      = DATA_W
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          s_wr_en,
    input  logic [NUM_REQ*DATA_W-1:0]   s_wr_data,
    output logic [NUM_REQ-1:0]          s_wr_full,
    output logic                        m_wr_en,
    output logic [OUT_W-1:0]            m_wr_data,
    input  logic                        m_wr_full,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_idx
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam bit                   LIMITED  = (BURST_LEN != 0);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = LIMITED ? CNT_WIDTH'(BURST_LEN - 1) : '0;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     grant_idx_nxt;
    logic [IDX_W-1:0]     last_grant, last_grant_nxt;
    logic [CNT_WIDTH-1:0] beat_cnt, beat_cnt_nxt;

    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic [DATA_W-1:0]    sel_data;
    logic                 req_g;

    // Rotating priority search: first requester at or after last_grant+1.
    // Walking from the farthest candidate to the nearest lets the nearest win.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (s_wr_en[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Mux the granted requester's data slice and request bit.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_data = s_wr_data[i*DATA_W +: DATA_W];
            end
        end
        req_g = s_wr_en[grant_idx];
    end

    // Fifo-side and requester-side handshakes; reset blocks any beat.
    always_comb begin
        s_wr_full   = '1;
        m_wr_en     = 1'b0;
        m_wr_data   = '0;
        grant_valid = (state == BURST);
        if (state == BURST) begin
`ifdef FIFO_WR_ARB_ID_TAG_EN
            m_wr_data = {grant_idx, sel_data};
`else
            m_wr_data = sel_data;
`endif
            if (!rst) begin
                m_wr_en              = req_g & ~m_wr_full;
                s_wr_full[grant_idx] = m_wr_full;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in BURST.
    always_comb begin
        state_nxt      = state;
        grant_idx_nxt  = grant_idx;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_idx_nxt = pick_idx;
                    beat_cnt_nxt  = '0;
                    state_nxt     = BURST;
                end
            end
            BURST: begin
                if (!req_g) begin
                    // Requester went idle: release without transferring.
                    state_nxt      = IDLE;
                    last_grant_nxt = grant_idx;
                end else if (m_wr_en) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (LIMITED && (beat_cnt == LAST_CNT)) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = grant_idx;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with synchronous reset; priority restarts at requester 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= LAST_IDX;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant_idx  <= grant_idx_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

endmodule
